// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage pipeline sequencer.
// Produces fetch/decode enables, ID/EX latch enables, RF write enable and the
// flush / hazflush controls. Handles load-use bubbles (one cycle), taken
// branch flushes (FLUSH_CYCLES cycles) and data-memory freezes.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the load-use stall and
// taken-branch event counters; otherwise stall_cnt/flush_cnt are tied to 0.
//
// Handshake note: there is no valid/ready pair here. dmem_ready acts as a
// global "advance" qualifier: when it is low at a clock edge the sequencer
// enters MEM_WAIT and the whole pipeline holds until it is seen high again.
//
// state_dbg exposes the FSM state (0 RUN, 1 LU_STALL, 2 BR_FLUSH, 3 MEM_WAIT).
module decode_hazard_ctrl #(
  parameter int NBITS        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] ir_id,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             rega_en,
  output logic             regb_en,
  output logic             regimm_en,
  output logic             rf_we,
  output logic             flush,
  output logic             hazflush,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_BR_FLUSH = 2'd2,
    S_MEM_WAIT = 2'd3
  } state_t;

  // Flush counter holds "remaining flush cycles minus one".
  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  state_t     saved, saved_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2;
  logic       lu;

  // Only the opcode and source register fields matter for hazard detection.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_id[NBITS-1:25], ir_id[14:7]};

  assign opcode = ir_id[6:0];
  assign rs1    = ir_id[19:15];
  assign rs2    = ir_id[24:20];

  // Decode which source registers the instruction in ID actually reads.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011: uses_rs1 = 1'b1;
      7'b0000011: uses_rs1 = 1'b1;
      7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100111: uses_rs1 = 1'b1;
      default: begin uses_rs1 = 1'b0; uses_rs2 = 1'b0; end
    endcase
  end

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

  // State, saved-state and flush-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      saved <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; priority is memory freeze, then branch, then load-use.
  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    cnt_nxt   = cnt;
    case (state)
      S_RUN: begin
        if (!dmem_ready) begin
          state_nxt = S_MEM_WAIT;
          saved_nxt = S_RUN;
        end else if (branch_taken) begin
          state_nxt = S_BR_FLUSH;
          cnt_nxt   = CNT_RELOAD;
        end else if (lu) begin
          state_nxt = S_LU_STALL;
        end
      end
      S_LU_STALL: begin
        // The bubble is already issued, so a freeze resumes into RUN.
        if (!dmem_ready) begin
          state_nxt = S_MEM_WAIT;
          saved_nxt = S_RUN;
        end else if (branch_taken) begin
          state_nxt = S_BR_FLUSH;
          cnt_nxt   = CNT_RELOAD;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_BR_FLUSH: begin
        if (!dmem_ready) begin
          state_nxt = S_MEM_WAIT;
          saved_nxt = S_BR_FLUSH;
        end else if (branch_taken) begin
          cnt_nxt = CNT_RELOAD;
        end else if (cnt == 3'd0) begin
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) state_nxt = saved;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Pipeline enables and flush controls, forced safe while in reset.
  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    rega_en   = 1'b0;
    regb_en   = 1'b0;
    regimm_en = 1'b0;
    flush     = 1'b0;
    hazflush  = 1'b0;
    case (state)
      S_RUN: begin
        pc_en = 1'b1; ifid_en = 1'b1;
        rega_en = 1'b1; regb_en = 1'b1; regimm_en = 1'b1;
      end
      S_LU_STALL: begin
        rega_en = 1'b1; regb_en = 1'b1; regimm_en = 1'b1;
        hazflush = 1'b1;
      end
      S_BR_FLUSH: begin
        pc_en = 1'b1; ifid_en = 1'b1;
        rega_en = 1'b1; regb_en = 1'b1; regimm_en = 1'b1;
        flush = 1'b1;
      end
      default: begin
        pc_en = 1'b0;
      end
    endcase
    if (!rst) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      rega_en   = 1'b0;
      regb_en   = 1'b0;
      regimm_en = 1'b0;
      flush     = 1'b1;
      hazflush  = 1'b0;
    end
  end

  // WB writes are suppressed for x0 and while the pipeline is frozen.
  assign rf_we = wb_regwrite && (wb_rd != 5'd0) && (state != S_MEM_WAIT) && rst;

  assign state_dbg = state;

`ifdef HAZ_PERF_CNT_EN
  logic br_event;
  assign br_event = dmem_ready && branch_taken && (state != S_MEM_WAIT);

  logic [31:0] stall_q, flush_q;

  // Performance counters: stall cycles and taken-branch entries into flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (state == S_LU_STALL) stall_q <= stall_q + 32'd1;
      if (br_event)            flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_decode_hazard_ctrl;

  localparam int F = 2;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: pc, ifid, a, b, imm, rf_we, flush, hazflush
  localparam logic [7:0] V_RST    = 8'b00000010;
  localparam logic [7:0] V_RUN    = 8'b11111000;
  localparam logic [7:0] V_RUN_WE = 8'b11111100;
  localparam logic [7:0] V_STALL  = 8'b00111001;
  localparam logic [7:0] V_FLUSH  = 8'b11111010;
  localparam logic [7:0] V_FL_WE  = 8'b11111110;
  localparam logic [7:0] V_FROZEN = 8'b00000000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ir_id;
  logic [4:0]  ex_rd, wb_rd;
  logic        ex_memread, branch_taken, dmem_ready, wb_regwrite;
  logic        pc_en, ifid_en, rega_en, regb_en, regimm_en, rf_we, flush, hazflush;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  state_dbg;
  logic [7:0]  obs;

  assign obs = {pc_en, ifid_en, rega_en, regb_en, regimm_en, rf_we, flush, hazflush};

  decode_hazard_ctrl #(.NBITS(32), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .ir_id(ir_id), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .pc_en(pc_en), .ifid_en(ifid_en), .rega_en(rega_en),
    .regb_en(regb_en), .regimm_en(regimm_en), .rf_we(rf_we), .flush(flush),
    .hazflush(hazflush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // Pipeline condition tracked as: frozen by memory, bubble being issued,
  // or number of flush cycles still owed (0 = not flushing).
  bit          m_frozen;
  bit          m_bubble;
  int          m_flush_left;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  function automatic bit model_lu(input logic [31:0] ir, input logic [4:0] rd, input logic mr);
    logic [6:0] op;
    bit r1, r2;
    op = ir[6:0];
    r1 = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
         (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b1100111);
    r2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    return mr && (rd != 5'd0) && ((r1 && ir[19:15] == rd) || (r2 && ir[24:20] == rd));
  endfunction

  function automatic logic [7:0] model_vec();
    logic we;
    we = wb_regwrite && (wb_rd != 5'd0) && !m_frozen;
    if (!rst)              return V_RST;
    if (m_frozen)          return V_FROZEN;
    if (m_bubble)          return {5'b00111, we, 2'b01};
    if (m_flush_left > 0)  return {5'b11111, we, 2'b10};
    return {5'b11111, we, 2'b00};
  endfunction

  function automatic logic [31:0] exp_stalls();
    return PERF ? m_stalls : 32'd0;
  endfunction

  function automatic logic [31:0] exp_flushes();
    return PERF ? m_flushes : 32'd0;
  endfunction

  task automatic model_reset();
    m_frozen = 0; m_bubble = 0; m_flush_left = 0;
    m_stalls = 32'd0; m_flushes = 32'd0;
  endtask

  task automatic model_step();
    bit lu;
    if (!rst) begin
      model_reset();
      return;
    end
    lu = model_lu(ir_id, ex_rd, ex_memread);
    if (m_frozen) begin
      if (dmem_ready) m_frozen = 0;
    end else begin
      if (m_bubble) m_stalls = m_stalls + 32'd1;
      if (!dmem_ready) begin
        m_frozen = 1;
        m_bubble = 0;
      end else if (branch_taken) begin
        m_flush_left = F;
        m_bubble = 0;
        m_flushes = m_flushes + 32'd1;
      end else if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
      end else if (m_bubble) begin
        m_bubble = 0;
      end else if (lu) begin
        m_bubble = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    ir_id = 32'h00000013; ex_rd = 5'd0; ex_memread = 1'b0;
    branch_taken = 1'b0; dmem_ready = 1'b1; wb_rd = 5'd0; wb_regwrite = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== V_FLUSH) begin
      errors++; $display("FAIL reset_pre_flush got %b exp %b", obs, V_FLUSH);
    end
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== V_RST) begin
      errors++; $display("FAIL reset_forced got %b exp %b", obs, V_RST);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== V_RUN) begin
      errors++; $display("FAIL reset_release got %b exp %b", obs, V_RUN);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", state_dbg);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; ir_id = 32'h00528333;
    @(negedge clk);
    checks++;
    if (obs !== V_RUN) begin
      errors++; $display("FAIL lu_detect_cycle got %b exp %b", obs, V_RUN);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (obs !== V_STALL) begin
      errors++; $display("FAIL lu_bubble got %b exp %b", obs, V_STALL);
    end
    tick();
    @(negedge clk);
    checks++;
    if (obs !== V_RUN) begin
      errors++; $display("FAIL lu_after got %b exp %b", obs, V_RUN);
    end
    checks++;
    if (stall_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, PERF ? 1 : 0);
    end
    tick();
  endtask

  task automatic test_no_false_hazard();
    logic [31:0] irs [3];
    logic [4:0]  rds [3];
    do_reset();
    irs[0] = 32'h00000033; rds[0] = 5'd0;  // add x0,x0,x0 against ex_rd=0
    irs[1] = 32'h005002B7; rds[1] = 5'd0;  // lui x5
    irs[2] = 32'h005002B7; rds[2] = 5'd5;  // lui: rs2 field equals ex_rd but unused
    for (int i = 0; i < 3; i++) begin
      ex_memread = 1'b1; ir_id = irs[i]; ex_rd = rds[i];
      tick();
      @(negedge clk);
      checks++;
      if (obs !== V_RUN) begin
        errors++; $display("FAIL no_false_hazard_%0d got %b exp %b", i, obs, V_RUN);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== V_FLUSH) begin
        errors++; $display("FAIL branch_flush_%0d got %b exp %b", i, obs, V_FLUSH);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== V_RUN) begin
      errors++; $display("FAIL branch_end got %b exp %b", obs, V_RUN);
    end
    checks++;
    if (flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL branch_flush_cnt got %0d exp %0d", flush_cnt, PERF ? 1 : 0);
    end
    tick();
  endtask

  task automatic test_branch_reload();
    logic [7:0] seq [5];
    seq[0] = V_FLUSH; seq[1] = V_FLUSH; seq[2] = V_FLUSH; seq[3] = V_RUN; seq[4] = V_RUN;
    do_reset();
    branch_taken = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      branch_taken = (i == 0);   // second branch during first flush cycle reloads
      @(negedge clk);
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL reload_%0d got %b exp %b", i, obs, seq[i]);
      end
      tick();
    end
    checks++;
    if (flush_cnt !== (PERF ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL reload_flush_cnt got %0d exp %0d", flush_cnt, PERF ? 2 : 0);
    end
  endtask

  task automatic test_freeze_mid_flush();
    logic [7:0] seq [6];
    logic       rdy [6];
    // cycle: flush, flush(drop ready), frozen, frozen, frozen(ready back), flush
    seq[0] = V_FLUSH;  rdy[0] = 1;
    seq[1] = V_FL_WE;  rdy[1] = 0;
    seq[2] = V_FROZEN; rdy[2] = 0;
    seq[3] = V_FROZEN; rdy[3] = 0;
    seq[4] = V_FROZEN; rdy[4] = 1;
    seq[5] = V_FL_WE;  rdy[5] = 1;
    do_reset();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dmem_ready = rdy[i];
      wb_regwrite = (i > 0); wb_rd = 5'd7;
      @(negedge clk);
      checks++;
      if (obs !== seq[i]) begin
        errors++; $display("FAIL freeze_%0d got %b exp %b", i, obs, seq[i]);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (obs !== V_RUN_WE) begin
      errors++; $display("FAIL freeze_resume_end got %b exp %b", obs, V_RUN_WE);
    end
    wb_rd = 5'd0;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL rf_we_x0 got %b exp 0", rf_we);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; ir_id = 32'h00528333; branch_taken = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (obs !== V_FLUSH) begin
      errors++; $display("FAIL simul_state got %b exp %b", obs, V_FLUSH);
    end
    tick();
    tick();
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL simul_counters got %0d/%0d exp 0/%0d", stall_cnt, flush_cnt, PERF ? 1 : 0);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    logic [7:0] exp;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1100111; ops[6] = 7'b0110111; ops[7] = 7'b1101111;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ir_id = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               3'($urandom), 5'($urandom), ops[$urandom_range(0, 7)]};
      ex_rd        = 5'($urandom_range(0, 7));
      ex_memread   = ($urandom_range(0, 1) == 1);
      branch_taken = ($urandom_range(0, 9) == 0);
      dmem_ready   = ($urandom_range(0, 5) != 0);
      wb_rd        = 5'($urandom_range(0, 3));
      wb_regwrite  = ($urandom_range(0, 1) == 1);
      exp_q.push_back(model_vec());
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random_out cyc %0d got %b exp %b", n, obs, exp);
      end
      checks++;
      if (stall_cnt !== exp_stalls() || flush_cnt !== exp_flushes()) begin
        errors++; $display("FAIL random_cnt cyc %0d got %0d/%0d exp %0d/%0d",
                           n, stall_cnt, flush_cnt, exp_stalls(), exp_flushes());
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_branch();
    test_branch_reload();
    test_freeze_mid_flush();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
Pipeline sequencer for the decode stage. Generates PC/IF-ID enables, the ID/EX latch enables (A, B, IMM), RF write enable, `flush` and `hazflush` for the decode unit. Resolves three conditions:
- load-use hazards: one-cycle bubble;
- taken branches/jumps from EX: multi-cycle flush;
- data-memory wait: full pipeline freeze.

Sits between the control unit and the decode/fetch datapath.

Parameters:
NBITS, 32, instruction width (ir_id)
FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch (1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ir_id  in  NBITS  instruction currently in decode
ex_rd  in  5  destination register of instruction in EX
ex_memread  in  1  EX instruction is a load
branch_taken  in  1  EX resolved taken branch/jump (held by EX while frozen)
dmem_ready  in  1  data memory ready; 0 = freeze
wb_rd  in  5  WB destination register
wb_regwrite  in  1  WB instruction writes RF
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
rega_en  out  1  to RegA_LATCH_EN
regb_en  out  1  to RegB_LATCH_EN
regimm_en  out  1  to RegIMM_LATCH_EN
rf_we  out  1  to RF_WE
flush  out  1  control-hazard flush of IF/ID and ID/EX
hazflush  out  1  load-use bubble into ID/EX
stall_cnt  out  32  load-use stall cycles (see optional feature)
flush_cnt  out  32  taken-branch events (see optional feature)

Behaviour:

Reset:
- rst=0 (async): state=RUN, flush counter=0, saved state=RUN.
- While rst=0, outputs are forced: pc_en, ifid_en, rega_en, regb_en, regimm_en, rf_we = 0; flush=1; hazflush=0.

Register use, decoded from ir_id[6:0]:
- uses_rs1 for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- uses_rs2 for opcodes 0110011, 0100011, 1100011.
- rs1=ir_id[19:15], rs2=ir_id[24:20].

Hazard condition:
- lu = ex_memread & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).

States: RUN, LU_STALL, BR_FLUSH, MEM_WAIT.

Next-state priority, evaluated each edge: dmem_ready=0 > branch_taken > lu > default.
- RUN:
  - dmem_ready=0 -> MEM_WAIT, saved=RUN.
  - branch_taken -> BR_FLUSH, cnt=FLUSH_CYCLES-1.
  - lu -> LU_STALL.
  - else RUN.
- LU_STALL (exactly one cycle):
  - dmem_ready=0 -> MEM_WAIT, saved=RUN.
  - branch_taken -> BR_FLUSH; the stalled instruction is discarded.
  - else RUN.
- BR_FLUSH:
  - dmem_ready=0 -> MEM_WAIT, saved=BR_FLUSH, cnt held.
  - branch_taken -> reload cnt=FLUSH_CYCLES-1.
  - cnt==0 -> RUN.
  - else cnt-1.
- MEM_WAIT:
  - Stay while dmem_ready=0.
  - On dmem_ready=1, return to saved state with cnt unchanged.
  - branch_taken/lu are ignored while frozen.

Outputs (combinational from state and inputs, rst=1):
- RUN: all enables=1, flush=0. hazflush=0.
  - lu is not acted on in the detecting cycle; the bubble is inserted in LU_STALL.
- LU_STALL: pc_en=0, ifid_en=0, rega/regb/regimm_en=1, hazflush=1, flush=0.
- BR_FLUSH: pc_en=1, ifid_en=1, latch enables=1, flush=1, hazflush=0.
- MEM_WAIT: pc_en, ifid_en, rega/regb/regimm_en = 0; flush=0; hazflush=0.
- FLUSH_CYCLES=1: a single flush cycle, then RUN.

rf_we = wb_regwrite & (wb_rd!=0) & (state!=MEM_WAIT) & rst.
- Writes to x0 are never enabled.
- No WB write occurs while frozen; WB holds its instruction.

Timing:
- Load-use: exactly 1 bubble per hazard.
- Taken branch: exactly FLUSH_CYCLES flush cycles, excluding frozen cycles.

Optional Feature:
Macro HAZ_PERF_CNT_EN.

Defined:
- stall_cnt increments once per cycle in LU_STALL.
- flush_cnt increments on each transition into BR_FLUSH, including reloads.
- Both are 32-bit and wrap 0xFFFFFFFF->0.
- Both are cleared by rst.
- Both hold during MEM_WAIT.

Undefined:
- Counter logic is absent; stall_cnt and flush_cnt are tied to 0.

Test Plan:
1. Reset: rst=0 mid-BR_FLUSH.
   -> Immediately: enables=0, flush=1.
   -> After release: RUN, all enables=1, flush=0.
2. Load-use: ex_memread=1, ex_rd=5, ir_id=0x00528333 (add x6,x5,x5).
   -> Next cycle: pc_en=0, ifid_en=0, hazflush=1 for exactly 1 cycle, then RUN. stall_cnt=1 with HAZ_PERF_CNT_EN.
3. No false hazards:
   - ex_rd=0 with ex_memread=1 -> no stall.
   - ir_id=0x005002B7 (lui x5, uses neither rs1 nor rs2) with ex_rd=0 -> no stall.
4. Taken branch, FLUSH_CYCLES=2: branch_taken pulse.
   -> flush=1 for 2 cycles, pc_en=1 throughout; flush_cnt=1.
5. Freeze mid-flush:
   - Branch, then dmem_ready=0 for 3 cycles after the first flush cycle.
   - -> All enables and flush=0 during the freeze, rf_we=0 even with wb_regwrite=1, wb_rd=7.
   - -> After resume: exactly 1 more flush cycle.
6. Simultaneous events: branch_taken=1 and lu=1 in RUN.
   -> BR_FLUSH, no LU_STALL; stall_cnt unchanged.
